fjd_array: RTL and testbench
============================

# fjd_array

Parametrised bank of WIDTH JK flip-flops sharing one clock and one asynchronous clear, with selectable per-bit JK, synchronous up/down counter, shift-register and parallel-load modes. It is the generalised successor of the single-bit JK cell in the simulation cell library, used where the original netlist chains JK flops into counters, shifters or flag registers. Carry/terminal-count and serial outputs allow cascading banks.

## Interface
- WIDTH, 8: number of flops (1..32).
- RESET_VAL, {WIDTH{1'b0}}: value forced onto Q by CL.
- CK  in  1  clock; all state changes on rising edge.
- CL  in  1  asynchronous, active-high clear; Q <= RESET_VAL while high.
- CE  in  1  clock enable; 0 holds Q in every mode.
- MODE  in  2  00 JK, 01 count, 10 shift, 11 load.
- J  in  WIDTH  per-bit J (mode 00); parallel data (mode 11).
- K  in  WIDTH  per-bit K (mode 00).
- UP  in  1  count direction (mode 01): 1 up, 0 down.
- SI  in  1  serial input (mode 10), enters bit 0.
- Q  out  WIDTH  flop outputs.
- nQ  out  WIDTH  ~Q, combinational.
- CO  out  1  terminal count: CE & MODE==01 & (UP ? Q==all ones : Q==0), combinational.
- SO  out  1  Q[WIDTH-1], serial output.

## Operation
- Reset: CL high -> Q = RESET_VAL immediately, independent of CK; nQ = ~RESET_VAL; CO follows its equation (low unless MODE==01 and CE); SO = RESET_VAL[WIDTH-1].
- CL dominates: rising CK while CL high leaves Q = RESET_VAL. CL deasserting between edges: first rising edge with CL low applies normal mode behaviour.
- CE low: Q holds, all modes.
- Mode 00 (JK), per bit i: {J,K} = 00 hold, 01 clear, 10 set, 11 toggle. Bits fully independent.
- Mode 01 (count): JK toggle chain. Bit 0 toggles every enabled edge; bit i toggles when all lower bits are 1 (up) or all 0 (down). Arithmetic modulo 2^WIDTH: all ones +1 -> 0, 0 -1 -> all ones. J/K ignored.
- Mode 10 (shift): Q <= {Q[WIDTH-2:0], SI}; WIDTH==1 -> Q <= SI.
- Mode 11 (load): Q <= J.
- MODE, UP, J, K, SI sampled only at rising CK; changes between edges affect only CO combinationally.
- Cascading: CO of a lower bank drives CE of the next bank on the same CK for wider counters.

## Timing
- CK rising -> Q valid after 2 ns (behavioural delay); CL rising -> Q = RESET_VAL after 1 ns.
- nQ, CO, SO: zero added delay relative to Q/inputs.
- Latency: one CK edge for every mode; no pipeline.
- Mode change takes effect on the same edge it is sampled; no state carried between modes other than Q.
- Q power-up (before first CL) = RESET_VAL.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, Q arbitrary, pulse CL between edges -> Q=8'hA5 within 1 ns, nQ=8'h5A; clock 3 edges with CL high -> Q stays 8'hA5.
- JK mode: Q=8'h0F, J=8'h33, K=8'h55, CE=1 -> one edge gives Q=8'h3A (bits: 11 toggle, 10 set, 01 clear, 00 hold).
- Count up wrap: load 8'hFE, MODE=01, UP=1 -> Q 8'hFF (CO=1) then 8'h00 (CO=0); UP=0 from 8'h00 -> CO=1, next edge 8'hFF.
- CE hold: counting at 8'h10, CE low for 4 edges -> Q stays 8'h10, CO=0; CE high -> 8'h11.
- Shift: Q=8'h00, MODE=10, SI sequence 1,0,1,1 -> Q=8'h0B, SO=0; 4 more edges SI=0 -> Q=8'hB0, SO=1.
- Cascade/async: two WIDTH=4 banks, low CO -> high CE, count up from 8'h0F -> 8'h10 in one edge; assert CL mid-count -> both banks RESET_VAL immediately, count resumes from it on first edge after release.

Source files
------------

// File: rtl/fjd_array_if.sv
// Control and data bundle for one fjd_array bank: mode/data inputs, flop outputs and cascade taps.
interface fjd_array_if #(parameter int WIDTH = 8);
  logic             CE;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             UP;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] nQ;
  logic             CO;
  logic             SO;

  modport master (output CE, MODE, J, K, UP, SI, input Q, nQ, CO, SO);
  modport slave  (input CE, MODE, J, K, UP, SI, output Q, nQ, CO, SO);
endinterface

// File: rtl/fjd_array.sv
// Bank of WIDTH JK flops with per-bit JK, up/down count, shift and parallel-load modes.
// CO/SO let several banks be chained into wider counters or shift registers.
module fjd_jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       CK,
  input  logic       CL,
  input  logic       i_ce,
  input  logic [1:0] i_mode,
  input  logic       i_j,
  input  logic       i_k,
  input  logic       i_tgl,
  input  logic       i_sin,
  output logic       o_q
);
  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    case (i_mode)
      2'b00: begin
        case ({i_j, i_k})
          2'b01:   w_d = 1'b0;
          2'b10:   w_d = 1'b1;
          2'b11:   w_d = ~r_q;
          default: w_d = r_q;
        endcase
      end
      2'b01:   w_d = r_q ^ i_tgl;
      2'b10:   w_d = i_sin;
      default: w_d = i_j;
    endcase
  end

  always_ff @(posedge CK or posedge CL) begin
    if (CL)        r_q <= RST_BIT;
    else if (i_ce) r_q <= w_d;
  end

  assign o_q = r_q;
endmodule

module fjd_array #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       CK,
  input  logic       CL,
  fjd_array_if.slave bus
);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_tgl;
  logic [WIDTH-1:0] w_sin;

  // Ripple toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic w_a1;
    logic w_a0;
    w_tgl = '0;
    w_a1  = 1'b1;
    w_a0  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_tgl[i] = bus.UP ? w_a1 : w_a0;
      w_a1     = w_a1 & w_q[i];
      w_a0     = w_a0 & ~w_q[i];
    end
  end

  generate
    if (WIDTH == 1) begin : g_sin1
      assign w_sin = bus.SI;
    end else begin : g_sinn
      assign w_sin = {w_q[WIDTH-2:0], bus.SI};
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      fjd_jk_cell #(.RST_BIT(RESET_VAL[g])) u_cell (
        .CK     (CK),
        .CL     (CL),
        .i_ce   (bus.CE),
        .i_mode (bus.MODE),
        .i_j    (bus.J[g]),
        .i_k    (bus.K[g]),
        .i_tgl  (w_tgl[g]),
        .i_sin  (w_sin[g]),
        .o_q    (w_q[g])
      );
    end
  endgenerate

  assign bus.Q  = w_q;
  assign bus.nQ = ~w_q;
  assign bus.SO = w_q[WIDTH-1];
  assign bus.CO = bus.CE & (bus.MODE == 2'b01) & (bus.UP ? (&w_q) : ~(|w_q));
endmodule

// File: tb/tb_fjd_array.sv
// Scoreboard bench for fjd_array: single 8-bit bank plus two cascaded 4-bit banks.
module tb_fjd_array;
  logic clk;
  logic cl;
  logic ccl;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  fjd_array_if #(.WIDTH(8)) ifm ();
  fjd_array_if #(.WIDTH(4)) ifl ();
  fjd_array_if #(.WIDTH(4)) ifh ();

  fjd_array #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (.CK(clk), .CL(cl), .bus(ifm));
  fjd_array #(.WIDTH(4), .RESET_VAL(4'h0)) u_lo (.CK(clk), .CL(ccl), .bus(ifl));
  fjd_array #(.WIDTH(4), .RESET_VAL(4'h0)) u_hi (.CK(clk), .CL(ccl), .bus(ifh));

  assign ifh.CE = ifl.CO;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic ce, input logic [1:0] mode, input logic [7:0] j,
                       input logic [7:0] k, input logic up, input logic si);
    ifm.CE = ce; ifm.MODE = mode; ifm.J = j; ifm.K = k; ifm.UP = up; ifm.SI = si;
  endtask

  task automatic test_reset;
    set_m(1'b1, 2'b11, 8'h3C, 8'h00, 1'b0, 1'b0);
    tick();
    checks++;
    if (ifm.Q !== 8'h3C) begin errors++; $display("FAIL preload got %h want %h", ifm.Q, 8'h3C); end
    #2 cl = 1'b1;
    #1;
    checks++;
    if (ifm.Q !== 8'hA5) begin errors++; $display("FAIL async_clear got %h want %h", ifm.Q, 8'hA5); end
    checks++;
    if (ifm.nQ !== 8'h5A) begin errors++; $display("FAIL reset_nq got %h want %h", ifm.nQ, 8'h5A); end
    checks++;
    if (ifm.SO !== 1'b1 || ifm.CO !== 1'b0) begin
      errors++; $display("FAIL reset_so_co got %b%b want 10", ifm.SO, ifm.CO);
    end
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(8'hA5);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ifm.Q !== e) begin errors++; $display("FAIL clear_dominates got %h want %h", ifm.Q, e); end
    end
    #2 cl = 1'b0;
  endtask

  task automatic test_jk;
    set_m(1'b1, 2'b11, 8'h0F, 8'h00, 1'b0, 1'b0);
    exp_q.push_back(8'h0F);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL load got %h want %h", ifm.Q, e); end
    set_m(1'b1, 2'b00, 8'h33, 8'h55, 1'b0, 1'b0);
    exp_q.push_back(8'h3A);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL jk_mode got %h want %h", ifm.Q, e); end
    checks++;
    if (ifm.nQ !== ~e) begin errors++; $display("FAIL jk_nq got %h want %h", ifm.nQ, ~e); end
  endtask

  task automatic test_count_wrap;
    set_m(1'b1, 2'b11, 8'hFE, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(8'hFE);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL load_fe got %h want %h", ifm.Q, e); end
    checks++;
    if (ifm.CO !== 1'b0) begin errors++; $display("FAIL co_load_mode got %b want 0", ifm.CO); end
    ifm.MODE = 2'b01;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e || ifm.CO !== 1'b1) begin
      errors++; $display("FAIL count_ff got %h co %b want %h co 1", ifm.Q, ifm.CO, e);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e || ifm.CO !== 1'b0) begin
      errors++; $display("FAIL count_wrap got %h co %b want %h co 0", ifm.Q, ifm.CO, e);
    end
    ifm.UP = 1'b0;
    #1;
    checks++;
    if (ifm.CO !== 1'b1) begin errors++; $display("FAIL co_down_zero got %b want 1", ifm.CO); end
    exp_q.push_back(8'hFF);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL count_down_wrap got %h want %h", ifm.Q, e); end
    exp_q.push_back(8'hFE);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL count_down got %h want %h", ifm.Q, e); end
  endtask

  task automatic test_ce_hold;
    set_m(1'b1, 2'b11, 8'h10, 8'h00, 1'b1, 1'b0);
    tick();
    set_m(1'b0, 2'b01, 8'hFF, 8'hFF, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(8'h10);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ifm.Q !== e || ifm.CO !== 1'b0) begin
        errors++; $display("FAIL ce_hold got %h co %b want %h co 0", ifm.Q, ifm.CO, e);
      end
    end
    ifm.CE = 1'b1;
    exp_q.push_back(8'h11);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ifm.Q !== e) begin errors++; $display("FAIL ce_resume got %h want %h", ifm.Q, e); end
  endtask

  task automatic test_shift;
    logic [7:0] m;
    logic       sib;
    logic [7:0] seq;
    set_m(1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    m   = 8'h00;
    seq = 8'b0000_1101;
    ifm.MODE = 2'b10;
    for (int n = 0; n < 8; n++) begin
      sib    = seq[n];
      ifm.SI = sib;
      m      = {m[6:0], sib};
      exp_q.push_back(m);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ifm.Q !== e || ifm.SO !== e[7]) begin
        errors++; $display("FAIL shift_%0d got %h so %b want %h so %b", n, ifm.Q, ifm.SO, e, e[7]);
      end
    end
    checks++;
    if (ifm.Q !== 8'hB0) begin errors++; $display("FAIL shift_final got %h want %h", ifm.Q, 8'hB0); end
  endtask

  task automatic test_cascade;
    ifh.MODE = 2'b01; ifh.UP = 1'b1; ifh.J = 4'h0; ifh.K = 4'h0; ifh.SI = 1'b0;
    ifl.CE = 1'b1; ifl.MODE = 2'b11; ifl.J = 4'hF; ifl.K = 4'h0; ifl.UP = 1'b1; ifl.SI = 1'b0;
    #2 ccl = 1'b0;
    exp_q.push_back(8'h0F);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ifh.Q, ifl.Q} !== e) begin errors++; $display("FAIL casc_load got %h want %h", {ifh.Q, ifl.Q}, e); end
    ifl.MODE = 2'b01;
    #1;
    checks++;
    if (ifl.CO !== 1'b1) begin errors++; $display("FAIL casc_co got %b want 1", ifl.CO); end
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    for (int n = 0; n < 3; n++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({ifh.Q, ifl.Q} !== e) begin errors++; $display("FAIL casc_count got %h want %h", {ifh.Q, ifl.Q}, e); end
    end
    #2 ccl = 1'b1;
    #1;
    checks++;
    if ({ifh.Q, ifl.Q} !== 8'h00) begin errors++; $display("FAIL casc_clear got %h want 00", {ifh.Q, ifl.Q}); end
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ifh.Q, ifl.Q} !== e) begin errors++; $display("FAIL casc_hold_clr got %h want %h", {ifh.Q, ifl.Q}, e); end
    #2 ccl = 1'b0;
    exp_q.push_back(8'h01);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ifh.Q, ifl.Q} !== e) begin errors++; $display("FAIL casc_resume got %h want %h", {ifh.Q, ifl.Q}, e); end
  endtask

  initial begin
    cl = 1'b1; ccl = 1'b1;
    set_m(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    ifl.CE = 1'b0; ifl.MODE = 2'b00; ifl.J = 4'h0; ifl.K = 4'h0; ifl.UP = 1'b0; ifl.SI = 1'b0;
    ifh.MODE = 2'b00; ifh.J = 4'h0; ifh.K = 4'h0; ifh.UP = 1'b0; ifh.SI = 1'b0;
    #12;
    checks++;
    if (ifm.Q !== 8'hA5) begin errors++; $display("FAIL reset_state got %h want %h", ifm.Q, 8'hA5); end
    cl = 1'b0;
    test_reset();
    test_jk();
    test_count_wrap();
    test_ce_hold();
    test_shift();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
